mem_arbiter: RTL and testbench

- Shares the single unified_mem port between the icache miss handler and the dcache miss/writeback handler.
- Accepts level-held requests, grants one requester at a time, and sequences dirty-line writeback followed by line fill as one atomic transaction.
- Returns the 64-bit line and a one-cycle ready pulse to the winning requester.
- Sits between the cache controllers and unified_mem. Drives the memory's addr/re/we/wdata and consumes its rd_data/rdy.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares unified_mem between icache fill and dcache writeback/fill.
// Optional watchdog enabled with `define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_rd_req,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_rd_addr,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              i_rdy,
    output logic              d_rdy,
    output logic              d_wb_done,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        I_RD = 2'd1,
        D_WR = 2'd2,
        D_RD = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              last_gnt_i;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] fill_addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              fill_pend_q;
    logic              d_req;
    logic              pick_d;
    logic              pick_i;
    logic              done;
    logic              tmo;

    // Round-robin pick: on a tie the side not served last wins.
    assign d_req  = d_rd_req | d_wr_req;
    assign pick_d = d_req && (!i_req || last_gnt_i);
    assign pick_i = i_req && !pick_d;
    assign done   = mem_rdy | tmo;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ?
                           $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;

    // Watchdog: counts busy cycles without mem_rdy, sticky error on expiry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE || done)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
            if (tmo)
                err_q <= 1'b1;
        end
    end

    assign tmo = (state != IDLE) && !mem_rdy &&
                 (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign err = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYC != 0);
    assign tmo        = 1'b0;
    assign err        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state: grant from IDLE, writeback chains into a pending fill.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (pick_d)
                    next_state = d_wr_req ? D_WR : D_RD;
                else if (pick_i)
                    next_state = I_RD;
            end
            I_RD, D_RD: begin
                if (done)
                    next_state = IDLE;
            end
            D_WR: begin
                if (done)
                    next_state = (fill_pend_q && !tmo) ? D_RD : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Grant latch: freeze the winner's address/data for the whole transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_i  <= 1'b1;
            addr_q      <= '0;
            fill_addr_q <= '0;
            wdata_q     <= '0;
            fill_pend_q <= 1'b0;
        end else if (state == IDLE) begin
            if (pick_d) begin
                last_gnt_i <= 1'b0;
                if (d_wr_req) begin
                    addr_q      <= d_wr_addr;
                    wdata_q     <= d_wdata;
                    fill_addr_q <= d_rd_addr;
                    fill_pend_q <= d_rd_req;
                end else begin
                    addr_q      <= d_rd_addr;
                    fill_pend_q <= 1'b0;
                end
            end else if (pick_i) begin
                last_gnt_i <= 1'b1;
                addr_q     <= i_addr;
            end
        end else if (state == D_WR && mem_rdy && fill_pend_q) begin
            addr_q <= fill_addr_q;
        end
    end

    // Outputs: strobes from registered state, pulses in the completion cycle.
    always_comb begin
        mem_re    = (state == I_RD) || (state == D_RD);
        mem_we    = (state == D_WR);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        i_rdy     = rst_n && (state == I_RD) && done;
        d_rdy     = rst_n && (state == D_RD) && done;
        d_wb_done = rst_n && (state == D_WR) && done;
        rd_data   = tmo ? '0 : mem_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus, expected completions queued in order
// and checked by an independent monitor against a small memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [13:0] i_addr;
    logic        d_rd_req;
    logic        d_wr_req;
    logic [13:0] d_rd_addr;
    logic [13:0] d_wr_addr;
    logic [63:0] d_wdata;
    logic        i_rdy;
    logic        d_rdy;
    logic        d_wb_done;
    logic [63:0] rd_data;
    logic [13:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_rdy;
    logic        err;

    typedef struct {
        int          kind;
        logic [13:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   lat   = 2;
    bit   hold_off  = 1'b0;
    bit   rdy_force = 1'b0;
    int   mcnt = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(14),
        .DATA_W(64),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_req(i_req),
        .i_addr(i_addr),
        .d_rd_req(d_rd_req),
        .d_wr_req(d_wr_req),
        .d_rd_addr(d_rd_addr),
        .d_wr_addr(d_wr_addr),
        .d_wdata(d_wdata),
        .i_rdy(i_rdy),
        .d_rdy(d_rdy),
        .d_wb_done(d_wb_done),
        .rd_data(rd_data),
        .mem_addr(mem_addr),
        .mem_re(mem_re),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_rdy(mem_rdy),
        .err(err)
    );

    function automatic logic [63:0] mdata(input logic [13:0] a);
        if (a == 14'h0123)
            return 64'hDEAD_BEEF_0000_1111;
        return {16'hCAFE, 34'h0, a};
    endfunction

    // Memory model: rdy on the lat-th strobe cycle.
    assign mem_rdy   = rdy_force ||
                       (!hold_off && (mem_re || mem_we) && (mcnt == lat - 1));
    assign mem_rdata = mdata(mem_addr);

    always @(posedge clk) begin
        if (!(mem_re || mem_we) || mem_rdy)
            mcnt <= 0;
        else
            mcnt <= mcnt + 1;
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, exp);
        end
    endtask

    task automatic push(input int kind, input logic [13:0] a,
                        input logic [63:0] d);
        exp_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    // Monitor: pops one expectation per completion pulse.
    exp_t        me;
    int          mk;
    logic [63:0] mdv;
    always @(negedge clk) begin
        if (i_rdy || d_rdy || d_wb_done) begin
            total++;
            mk  = d_wb_done ? 2 : (d_rdy ? 1 : 0);
            mdv = d_wb_done ? mem_wdata : rd_data;
            if ($countones({i_rdy, d_rdy, d_wb_done}) != 1) begin
                bad++;
                $display("FAIL multi_pulse: got %b, want one-hot",
                         {i_rdy, d_rdy, d_wb_done});
            end else if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got kind %0d addr %0h, want none",
                         mk, mem_addr);
            end else begin
                me = q.pop_front();
                if (mk != me.kind || mem_addr !== me.addr || mdv !== me.data) begin
                    bad++;
                    $display("FAIL completion: got k%0d a%0h d%0h, want k%0d a%0h d%0h",
                             mk, mem_addr, mdv, me.kind, me.addr, me.data);
                end
            end
        end
        if (mem_re && mem_we) begin
            total++;
            bad++;
            $display("FAIL re_we_overlap: got both, want exclusive");
        end
    end

    task automatic wait_pulse(input int kind);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 80 && !got; k++) begin
            @(negedge clk);
            if ((kind == 0 && i_rdy) || (kind == 1 && d_rdy) ||
                (kind == 2 && d_wb_done))
                got = 1'b1;
        end
        check($sformatf("pulse_seen_k%0d", kind), got, 1);
    endtask

    task automatic do_i(input logic [13:0] a);
        i_addr = a;
        i_req  = 1'b1;
        wait_pulse(0);
        @(posedge clk);
        #1 i_req = 1'b0;
    endtask

    task automatic do_d(input bit wr, input bit rd, input logic [13:0] wa,
                        input logic [13:0] ra, input logic [63:0] wd);
        d_wr_addr = wa;
        d_rd_addr = ra;
        d_wdata   = wd;
        d_wr_req  = wr;
        d_rd_req  = rd;
        if (wr) begin
            wait_pulse(2);
            @(posedge clk);
            #1 d_wr_req = 1'b0;
            if (rd) begin
                @(negedge clk);
                check("nogap_re", mem_re, 1);
                check("fill_addr", mem_addr, ra);
            end
        end
        if (rd) begin
            wait_pulse(1);
            @(posedge clk);
            #1 d_rd_req = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int  re_cnt;
        int  busy;
        bit  we_seen;
        bit  got;

        rst_n     = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_rd_req  = 1'b0;
        d_wr_req  = 1'b0;
        d_rd_addr = '0;
        d_wr_addr = '0;
        d_wdata   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_re", mem_re, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_pulses", {i_rdy, d_rdy, d_wb_done}, 0);
        check("rst_err", err, 0);

        // Tie after reset: dcache first.
        push(1, 14'h0040, mdata(14'h0040));
        push(0, 14'h0080, mdata(14'h0080));
        fork
            do_d(1'b0, 1'b1, 14'h0, 14'h0040, 64'h0);
            do_i(14'h0080);
        join
        // Lone dcache, then tie: icache first.
        @(negedge clk);
        push(1, 14'h0041, mdata(14'h0041));
        do_d(1'b0, 1'b1, 14'h0, 14'h0041, 64'h0);
        @(negedge clk);
        push(0, 14'h0081, mdata(14'h0081));
        push(1, 14'h0042, mdata(14'h0042));
        fork
            do_i(14'h0081);
            do_d(1'b0, 1'b1, 14'h0, 14'h0042, 64'h0);
        join

        // Single icache fill, 4-cycle memory.
        lat = 4;
        @(negedge clk);
        push(0, 14'h0123, 64'hDEAD_BEEF_0000_1111);
        i_addr  = 14'h0123;
        i_req   = 1'b1;
        re_cnt  = 0;
        we_seen = 1'b0;
        got     = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (k == 0)
                check("re_latency", mem_re, 1);
            if (mem_re)
                re_cnt++;
            if (mem_we)
                we_seen = 1'b1;
            if (i_rdy)
                got = 1'b1;
        end
        check("i_done_seen", got, 1);
        check("re_cycles", re_cnt, 4);
        check("we_never", we_seen, 0);
        @(posedge clk);
        #1 i_req = 1'b0;

        // Address held while requester input changes.
        lat = 5;
        @(negedge clk);
        push(0, 14'h0001, mdata(14'h0001));
        fork
            do_i(14'h0001);
            begin
                @(negedge clk);
                @(negedge clk);
                i_addr = 14'h3FFF;
                repeat (3) begin
                    @(negedge clk);
                    check("addr_hold", mem_addr, 14'h0001);
                end
            end
        join
        lat = 2;

        // Atomic writeback + fill with a competing icache request.
        @(negedge clk);
        push(2, 14'h0010, 64'hA5A5_A5A5_A5A5_A5A5);
        push(1, 14'h0020, mdata(14'h0020));
        push(0, 14'h0200, mdata(14'h0200));
        fork
            do_d(1'b1, 1'b1, 14'h0010, 14'h0020, 64'hA5A5_A5A5_A5A5_A5A5);
            begin
                @(negedge clk);
                do_i(14'h0200);
            end
        join

        // Fill raised during a lone writeback is not merged.
        @(negedge clk);
        push(2, 14'h0030, 64'h0123_4567_89AB_CDEF);
        push(1, 14'h0031, mdata(14'h0031));
        d_wr_addr = 14'h0030;
        d_rd_addr = 14'h0031;
        d_wdata   = 64'h0123_4567_89AB_CDEF;
        d_wr_req  = 1'b1;
        @(negedge clk);
        d_rd_req = 1'b1;
        wait_pulse(2);
        @(posedge clk);
        #1 d_wr_req = 1'b0;
        @(negedge clk);
        check("no_merge_idle", mem_re, 0);
        wait_pulse(1);
        @(posedge clk);
        #1 d_rd_req = 1'b0;

        // mem_rdy in IDLE is ignored.
        @(negedge clk);
        rdy_force = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_no_re", mem_re, 0);
        end
        rdy_force = 1'b0;

        // Reset during D_RD: no completion ever.
        lat = 6;
        @(negedge clk);
        d_rd_addr = 14'h0055;
        d_rd_req  = 1'b1;
        @(negedge clk);
        check("rst_pre_re", mem_re, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_re", mem_re, 0);
        check("rst_mid_addr", mem_addr, 0);
        rst_n    = 1'b1;
        d_rd_req = 1'b0;
        repeat (10) @(negedge clk);
        lat = 2;

`ifdef MEM_ARB_TIMEOUT_EN
        hold_off = 1'b1;
        @(negedge clk);
        push(0, 14'h0077, 64'h0);
        i_addr = 14'h0077;
        i_req  = 1'b1;
        busy   = 0;
        got    = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (mem_re)
                busy++;
            if (i_rdy)
                got = 1'b1;
        end
        check("tmo_seen", got, 1);
        check("tmo_cycles", busy, 8);
        @(posedge clk);
        #1 i_req = 1'b0;
        hold_off = 1'b0;
        @(negedge clk);
        check("tmo_err", err, 1);
        push(0, 14'h0078, mdata(14'h0078));
        do_i(14'h0078);
        @(negedge clk);
        check("tmo_err_sticky", err, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("tmo_err_clear", err, 0);
`else
        busy = 0;
        check("err_tied", err, busy);
`endif

        repeat (3) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
